// File: rtl/axi_b_pkg.sv
// Shared types and constants for the M1 write-response return path.
package axi_b_pkg;

  localparam int N_SRC   = 5;
  localparam int DEF_IDX = 4;
  localparam int B_ID_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [B_ID_W-1:0] id;
    logic [1:0]        resp;
  } b_entry_t;

endpackage

// File: rtl/b_fifo_mem.sv
// Response storage: one synchronous write port, one asynchronous read port.
module b_fifo_mem #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_b_resp_fifo.sv
// B-channel return stage for M1: muxes the granted source's response into a
// small FIFO and presents the head entry to M1.
import axi_b_pkg::*;

module axi_b_resp_fifo #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PTR_W = AW + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [N_SRC-1:0]      grant,
  input  logic [N_SRC*ID_W-1:0] BID_S,
  input  logic [N_SRC*2-1:0]    BRESP_S,
  input  logic [N_SRC-1:0]      BVALID_S,
  output logic [N_SRC-1:0]      BREADY_S,
  output logic [ID_W-1:0]       BID_M1,
  output logic [1:0]            BRESP_M1,
  output logic                  BVALID_M1,
  input  logic                  BREADY_M1,
  output logic [PTR_W-1:0]      count,
  output logic                  grant_err
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             grant_err_q, grant_err_d;

  logic             onehot;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head_entry;

  assign onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == PTR_W'(DEPTH));
  assign empty  = (count == '0);

  // Source readiness depends only on grant and occupancy, never on BREADY_M1.
  assign BREADY_S = (onehot && !full) ? grant : '0;
  assign push     = |(BVALID_S & BREADY_S);
  assign pop      = !empty && BREADY_M1;

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant[i]) begin
        push_entry.id   = BID_S[i*ID_W +: ID_W];
        push_entry.resp = (i == DEF_IDX) ? RESP_DECERR : BRESP_S[i*2 +: 2];
      end
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    grant_err_d = grant_err_q | (!onehot && (BVALID_S != '0));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      grant_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      grant_err_q <= grant_err_d;
    end
  end

  b_fifo_mem #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (ACLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (push_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_entry)
  );

  // Head fields are masked to zero when empty so stale storage never leaks out.
  assign BVALID_M1 = !empty;
  assign BID_M1    = empty ? '0 : head_entry.id;
  assign BRESP_M1  = empty ? '0 : head_entry.resp;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_axi_b_resp_fifo.sv
// Randomised and directed bench for axi_b_resp_fifo against a queue-based model.
module tb_axi_b_resp_fifo;
  import axi_b_pkg::*;

  localparam int ID_W  = 8;
  localparam int DEPTH = 4;

  logic                  ACLK;
  logic                  ARESET;
  logic [N_SRC-1:0]      grant;
  logic [N_SRC*ID_W-1:0] BID_S;
  logic [N_SRC*2-1:0]    BRESP_S;
  logic [N_SRC-1:0]      BVALID_S;
  logic [N_SRC-1:0]      BREADY_S;
  logic [ID_W-1:0]       BID_M1;
  logic [1:0]            BRESP_M1;
  logic                  BVALID_M1;
  logic                  BREADY_M1;
  logic [2:0]            count;
  logic                  grant_err;

  axi_b_resp_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .grant     (grant),
    .BID_S     (BID_S),
    .BRESP_S   (BRESP_S),
    .BVALID_S  (BVALID_S),
    .BREADY_S  (BREADY_S),
    .BID_M1    (BID_M1),
    .BRESP_M1  (BRESP_M1),
    .BVALID_M1 (BVALID_M1),
    .BREADY_M1 (BREADY_M1),
    .count     (count),
    .grant_err (grant_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int       checks   = 0;
  int       failures = 0;
  b_entry_t model_q[$];
  logic     model_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_SRC*ID_W-1:0] ids_with(input int idx, input logic [ID_W-1:0] id);
    logic [N_SRC*ID_W-1:0] v;
    v = {$urandom, $urandom};
    v[idx*ID_W +: ID_W] = id;
    return v;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic [4:0] g, input logic [4:0] v, input logic [39:0] ids,
                      input logic [9:0] resps, input logic rdy);
    logic     one_hot;
    int       sel;
    logic     do_push;
    logic     do_pop;
    b_entry_t e;
    grant = g; BVALID_S = v; BID_S = ids; BRESP_S = resps; BREADY_M1 = rdy;
    #2;
    one_hot = ($countones(g) == 1);
    sel = 0;
    for (int i = 0; i < N_SRC; i++) if (g[i]) sel = i;
    check("bready_s", BREADY_S, (one_hot && model_q.size() < DEPTH) ? g : 5'b0);
    check("bvalid_m1", BVALID_M1, model_q.size() != 0);
    check("count", count, model_q.size());
    check("bid_m1", BID_M1, model_q.size() != 0 ? model_q[0].id : 8'h0);
    check("bresp_m1", BRESP_M1, model_q.size() != 0 ? model_q[0].resp : 2'b0);
    check("grant_err", grant_err, model_err);
    do_push = one_hot && (model_q.size() < DEPTH) && v[sel];
    do_pop  = (model_q.size() != 0) && rdy;
    if (!one_hot && v != 0) model_err = 1'b1;
    if (do_pop) begin
      $display("pop  id=%02h resp=%0d", model_q[0].id, model_q[0].resp);
      void'(model_q.pop_front());
    end
    if (do_push) begin
      e.id   = ids[sel*ID_W +: ID_W];
      e.resp = (sel == DEF_IDX) ? RESP_DECERR : resps[sel*2 +: 2];
      model_q.push_back(e);
      $display("push src=%0d id=%02h resp=%0d", sel, e.id, e.resp);
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [4:0] g;
    ARESET = 1'b1; grant = '0; BID_S = '0; BRESP_S = '0; BVALID_S = '0; BREADY_M1 = 1'b0;
    #3;
    check("rst_bvalid", BVALID_M1, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_bid", BID_M1, 8'h0);
    check("rst_err", grant_err, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Single response from S1, popped the next cycle.
    step(5'b00001, 5'b00001, ids_with(0, 8'h15), 10'h0, 1'b0);
    step(5'b00000, 5'b00000, '0, '0, 1'b1);
    step(5'b00000, 5'b00000, '0, '0, 1'b0);

    // Default slave forces DECERR.
    step(5'b10000, 5'b10000, ids_with(4, 8'h3A), 10'h0, 1'b0);
    step(5'b00000, 5'b00000, '0, '0, 1'b1);

    // Fill to full, then drain with a competing push blocked in the first pop cycle.
    for (int i = 0; i < 4; i++)
      step(5'(1 << i), 5'(1 << i), ids_with(i, 8'hA0 + 8'(i)), 10'h2AA, 1'b0);
    step(5'b00001, 5'b00001, ids_with(0, 8'hB0), 10'h0, 1'b0);
    step(5'b00001, 5'b00001, ids_with(0, 8'hB1), 10'h0, 1'b1);
    step(5'b00010, 5'b00010, ids_with(1, 8'hB2), 10'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(5'b0, 5'b0, '0, '0, 1'b1);

    // Back-to-back push and pop at count=1.
    step(5'b00100, 5'b00100, ids_with(2, 8'hC0), 10'h3FF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int s = int'($urandom_range(0, 3));
      step(5'(1 << s), 5'(1 << s), ids_with(s, 8'(8'hC1 + i)), 10'($urandom), 1'b1);
    end
    step(5'b0, 5'b0, '0, '0, 1'b1);

    // Bad grant: no push, sticky error.
    step(5'b00011, 5'b00001, ids_with(0, 8'hDD), 10'h0, 1'b0);
    step(5'b00001, 5'b00000, '0, '0, 1'b0);
    step(5'b00001, 5'b00000, '0, '0, 1'b0);

    // Reset mid-stream with three entries held.
    for (int i = 0; i < 3; i++)
      step(5'b01000, 5'b01000, ids_with(3, 8'hE0 + 8'(i)), 10'h0, 1'b0);
    #3;
    ARESET = 1'b1;
    #1;
    check("mid_rst_bvalid", BVALID_M1, 1'b0);
    check("mid_rst_count", count, 3'd0);
    check("mid_rst_bid", BID_M1, 8'h0);
    check("mid_rst_err", grant_err, 1'b0);
    model_q.delete();
    model_err = 1'b0;
    grant = '0; BVALID_S = '0;
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Randomised traffic, mostly one-hot grants.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 90) g = 5'(1 << $urandom_range(0, 4));
      else g = 5'($urandom);
      step(g, 5'($urandom), {$urandom, $urandom}, 10'($urandom),
           1'($urandom_range(0, 99) < 55));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
